tl_fifo_arbiter: RTL and testbench

TL_FIFO_ARBITER -- requirements
Module: tl_fifo_arbiter

---
 rtl/tl_pkg.sv | 23 ++
 rtl/rr_arbiter4.sv | 26 ++
 rtl/tl_fifo_arbiter.sv | 113 +++++++++++
 tb/tb_tl_fifo_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared types and sizes for the VC-to-destination FIFO arbiter.
package tl_pkg;
  localparam int NUM_VC = 4;
  localparam int VC_W   = 2;
  localparam int DATA_W = 12;
  localparam int THR_W  = 3;

  typedef enum logic [3:0] {
    ST_RESET  = 4'b0001,
    ST_INIT   = 4'b0010,
    ST_IDLE   = 4'b0100,
    ST_ACTIVE = 4'b1000
  } state_e;

  function automatic logic [VC_W-1:0] onehot_idx(input logic [NUM_VC-1:0] oh);
    logic [VC_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (oh[i]) idx = idx | VC_W'(i);
    end
    return idx;
  endfunction
endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin grant: search starts one past the pointer and wraps.
// Purely combinational; grant is one-hot or zero when nothing is requested.
module rr_arbiter4 import tl_pkg::*; (
  input  logic [NUM_VC-1:0] request,
  input  logic [VC_W-1:0]   pointer,
  output logic [NUM_VC-1:0] grant
);

  logic [VC_W-1:0] idx;
  logic            found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    // k = NUM_VC wraps back to the pointer itself, so it is searched last
    for (int k = 1; k <= NUM_VC; k++) begin
      idx = pointer + VC_W'(k);
      if (!found && request[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tl_fifo_arbiter.sv
// Drains four VC FIFOs round-robin into one destination FIFO; pop to push is one cycle.
// Pops stall while destination is almost-full; overflow pushes raise a sticky err.
module tl_fifo_arbiter import tl_pkg::*; (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     init,
  input  logic [THR_W-1:0]         umbral_af_in,
  input  logic [THR_W-1:0]         umbral_ae_in,
  input  logic [NUM_VC-1:0]        src_empty,
  input  logic [NUM_VC*DATA_W-1:0] src_data,
  output logic [NUM_VC-1:0]        src_pop,
  input  logic                     dst_almost_full,
  input  logic                     dst_full,
  output logic                     dst_push,
  output logic [DATA_W-1:0]        dst_data,
  output logic [THR_W-1:0]         umbral_af_out,
  output logic [THR_W-1:0]         umbral_ae_out,
  output logic [3:0]               state,
  output logic                     err
);

  state_e            state_q, state_d;
  logic [THR_W-1:0]  af_q, af_d, ae_q, ae_d;
  logic [VC_W-1:0]   ptr_q, ptr_d;
  logic              push_q, push_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;

  logic [NUM_VC-1:0] req;
  logic [NUM_VC-1:0] grant;
  logic              any_req;
  logic              pop;

  assign req     = ~src_empty;
  assign any_req = |req;

  rr_arbiter4 u_rr (
    .request (req),
    .pointer (ptr_q),
    .grant   (grant)
  );

  always_comb begin
    state_d = state_q;
    af_d    = af_q;
    ae_d    = ae_q;
    pop     = 1'b0;
    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT: begin
        af_d = umbral_af_in;
        ae_d = umbral_ae_in;
        if (!init) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (init)         state_d = ST_INIT;
        else if (any_req) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (init) begin
          state_d = ST_INIT;
        end else begin
          pop = any_req && !dst_almost_full;
          if (!any_req) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  // Word captured on the pop edge so push and data move together next cycle
  always_comb begin
    ptr_d  = ptr_q;
    data_d = data_q;
    push_d = pop;
    err_d  = err_q | (push_q & dst_full);
    if (pop) begin
      ptr_d = onehot_idx(grant);
      for (int i = 0; i < NUM_VC; i++) begin
        if (grant[i]) data_d = src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RESET;
      af_q    <= '0;
      ae_q    <= '0;
      ptr_q   <= VC_W'(NUM_VC - 1);
      push_q  <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ptr_q   <= ptr_d;
      push_q  <= push_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign src_pop       = pop ? grant : '0;
  assign dst_push      = push_q;
  assign dst_data      = data_q;
  assign umbral_af_out = af_q;
  assign umbral_ae_out = ae_q;
  assign state         = state_q;
  assign err           = err_q;

endmodule

// File: tb/tb_tl_fifo_arbiter.sv
// Bench: queue-backed source FIFOs and a transaction-level model of the arbiter.
module tb_tl_fifo_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        init;
  logic [2:0]  af_in, ae_in;
  logic [3:0]  src_empty;
  logic [47:0] src_data;
  logic [3:0]  src_pop;
  logic        dst_almost_full, dst_full, dst_push;
  logic [11:0] dst_data;
  logic [2:0]  af_out, ae_out;
  logic [3:0]  state;
  logic        err;

  tl_fifo_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .init            (init),
    .umbral_af_in    (af_in),
    .umbral_ae_in    (ae_in),
    .src_empty       (src_empty),
    .src_data        (src_data),
    .src_pop         (src_pop),
    .dst_almost_full (dst_almost_full),
    .dst_full        (dst_full),
    .dst_push        (dst_push),
    .dst_data        (dst_data),
    .umbral_af_out   (af_out),
    .umbral_ae_out   (ae_out),
    .state           (state),
    .err             (err)
  );

  always #5 clk = ~clk;

  localparam int M_RST = 0, M_INIT = 1, M_IDLE = 2, M_ACT = 3;

  int          total, bad;
  int          m_st, m_last;
  bit          m_push, m_err;
  logic [11:0] m_data;
  logic [2:0]  m_af, m_ae;
  logic [11:0] mem [4][16];
  int          rd [4];
  int          cnt [4];

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] code(input int s);
    case (s)
      M_RST:   return 4'b0001;
      M_INIT:  return 4'b0010;
      M_IDLE:  return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  task automatic model_reset();
    m_st = M_RST; m_last = 3; m_push = 0; m_data = '0; m_err = 0; m_af = '0; m_ae = '0;
  endtask

  task automatic put(input int v, input logic [11:0] w);
    mem[v][(rd[v] + cnt[v]) % 16] = w;
    cnt[v]++;
  endtask

  task automatic drive_src();
    for (int v = 0; v < 4; v++) begin
      src_empty[v] = (cnt[v] == 0);
      src_data[v*12 +: 12] = (cnt[v] > 0) ? mem[v][rd[v]] : 12'($urandom);
    end
  endtask

  task automatic check_outs(input logic [3:0] exp_pop, input bit chk_data);
    chk("state", {8'b0, state}, {8'b0, code(m_st)});
    chk("src_pop", {8'b0, src_pop}, {8'b0, exp_pop});
    chk("dst_push", {11'b0, dst_push}, {11'b0, m_push});
    chk("err", {11'b0, err}, {11'b0, m_err});
    chk("umbral_af", {9'b0, af_out}, {9'b0, m_af});
    chk("umbral_ae", {9'b0, ae_out}, {9'b0, m_ae});
    if (chk_data) chk("dst_data", dst_data, m_data);
  endtask

  task automatic step(input logic i_rst, input logic i_init, input logic i_af,
                      input logic i_full, input logic [2:0] i_afin, input logic [2:0] i_aein);
    int vc;
    bit any;
    logic [3:0] exp_pop;
    @(negedge clk);
    reset = i_rst; init = i_init; dst_almost_full = i_af; dst_full = i_full;
    af_in = i_afin; ae_in = i_aein;
    drive_src();
    if (!i_rst) model_reset();
    #1;
    vc = -1;
    any = 0;
    for (int v = 0; v < 4; v++) if (cnt[v] > 0) any = 1;
    if (i_rst && m_st == M_ACT && !i_init && !i_af) begin
      for (int k = 1; k <= 4; k++) begin
        int v;
        v = (m_last + k) % 4;
        if (vc < 0 && cnt[v] > 0) vc = v;
      end
    end
    exp_pop = 4'b0;
    if (vc >= 0) exp_pop[vc] = 1'b1;
    check_outs(exp_pop, m_push || !i_rst);
    if (i_rst) begin
      m_err = m_err || (m_push && i_full);
      m_push = (vc >= 0);
      if (vc >= 0) begin
        m_data = mem[vc][rd[vc]];
        rd[vc] = (rd[vc] + 1) % 16;
        cnt[vc]--;
        m_last = vc;
      end
      case (m_st)
        M_RST:  m_st = M_INIT;
        M_INIT: begin
          m_af = i_afin; m_ae = i_aein;
          if (!i_init) m_st = M_IDLE;
        end
        M_IDLE: if (i_init) m_st = M_INIT; else if (any) m_st = M_ACT;
        default: if (i_init) m_st = M_INIT; else if (!any) m_st = M_IDLE;
      endcase
    end
  endtask

  // Reset asserted between clock edges must take effect without waiting for clk
  task automatic async_reset();
    @(negedge clk);
    drive_src();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_outs(4'b0, 1'b1);
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b0; init = 1'b0; af_in = '0; ae_in = '0;
    dst_almost_full = 1'b0; dst_full = 1'b0;
    src_empty = 4'hF; src_data = '0;
    for (int v = 0; v < 4; v++) begin rd[v] = 0; cnt[v] = 0; end
    model_reset();

    repeat (2) step(0, 1, 0, 0, 3'd7, 3'd0);
    // release with init held two cycles: RESET, INIT, INIT, IDLE
    step(1, 1, 0, 0, 3'd7, 3'd0);
    step(1, 1, 0, 0, 3'd7, 3'd0);
    step(1, 0, 0, 0, 3'd7, 3'd0);
    step(1, 0, 0, 0, 3'd7, 3'd0);

    put(0, 12'h00C); put(1, 12'h00D); put(2, 12'h00E); put(3, 12'h00F);
    repeat (7) step(1, 0, 0, 0, 3'd7, 3'd0);

    put(0, 12'h00A); put(0, 12'h00B);
    repeat (5) step(1, 0, 0, 0, 3'd7, 3'd0);

    put(1, 12'h123);
    step(1, 0, 0, 0, 3'd7, 3'd0);
    repeat (3) step(1, 0, 1, 0, 3'd7, 3'd0);
    repeat (3) step(1, 0, 0, 0, 3'd7, 3'd0);

    repeat (400) begin
      if ($urandom_range(2) == 0) begin
        int v;
        v = $urandom_range(3);
        if (cnt[v] < 8) put(v, 12'($urandom));
      end
      step(1, ($urandom_range(24) == 0), ($urandom_range(3) == 0), 1'b0,
           3'($urandom), 3'($urandom));
    end

    repeat (3) step(1, 0, 0, 0, 3'd5, 3'd2);
    put(2, 12'h0A1); put(2, 12'h0A2); put(2, 12'h0A3);
    repeat (4) step(1, 0, 0, 1, 3'd5, 3'd2);
    repeat (2) step(1, 0, 0, 0, 3'd5, 3'd2);
    chk("err_sticky", {11'b0, err}, 12'd1);

    put(2, 12'h0B1); put(2, 12'h0B2); put(2, 12'h0B3); put(2, 12'h0B4);
    repeat (2) step(1, 0, 0, 0, 3'd5, 3'd2);
    async_reset();
    repeat (2) step(0, 0, 0, 0, 3'd5, 3'd2);
    step(1, 1, 0, 0, 3'd4, 3'd1);
    step(1, 0, 0, 0, 3'd4, 3'd1);

    repeat (150) begin
      if ($urandom_range(1) == 0) begin
        int v;
        v = $urandom_range(3);
        if (cnt[v] < 8) put(v, 12'($urandom));
      end
      step(1, ($urandom_range(30) == 0), ($urandom_range(3) == 0),
           ($urandom_range(7) == 0), 3'($urandom), 3'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
